// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
// Both the arbiter and its MC write FIFO import this package.
package regfile_pkg;

   localparam int DATA_W     = 32;
   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS   = 32;

   // r0 is hard-wired to zero in the register file; writes to it are dropped.
   localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

   // One queued multi-cycle-unit write.
   typedef struct packed {
      logic [REG_ADDR_W-1:0] addr;
      logic [DATA_W-1:0]     data;
   } mc_req_t;

   // Who owns the write port in the current cycle.
   typedef enum logic [1:0] {
      GRANT_IDLE = 2'd0,
      GRANT_WB   = 2'd1,
      GRANT_MC   = 2'd2
   } grant_e;

   // Starvation guard: normal running, or asking the pipeline for a bubble.
   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_STALL = 1'b1
   } starve_state_e;

   // Decode a register address into a one-hot register mask.
   function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] addr);
      logic [NUM_REGS-1:0] mask;
      mask       = '0;
      mask[addr] = 1'b1;
      return mask;
   endfunction

endpackage

// File: rtl/mc_wr_fifo.sv
// Synchronous FIFO for multi-cycle-unit register writes.
// Besides the head entry it exposes the occupancy and the destination
// address / validity of every slot, so the arbiter can build the
// pending-write vector without a second copy of the queue.
module mc_wr_fifo
   import regfile_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                push,
   input  mc_req_t                             push_req,
   input  logic                                pop,
   output mc_req_t                             head,
   output logic [$clog2(DEPTH):0]              count,
   output logic                                empty,
   output logic [DEPTH-1:0][REG_ADDR_W-1:0]    entry_addr,
   output logic [DEPTH-1:0]                    entry_valid
);

   localparam int              PTR_W      = $clog2(DEPTH);
   localparam logic [PTR_W:0]  FULL_COUNT = (PTR_W + 1)'(DEPTH);
   localparam logic [PTR_W:0]  CNT_ONE    = (PTR_W + 1)'(1);
   localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

   mc_req_t          mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count_q;
   logic             full;
   logic             do_push;
   logic             do_pop;

   assign full    = (count_q == FULL_COUNT);
   assign empty   = (count_q == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign count   = count_q;
   assign head    = mem[rd_ptr];

   // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
   // NOTE: sequential state is assigned with <= so every register samples
   // the pre-edge values of its neighbours, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
         unique case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CNT_ONE;
            2'b01:   count_q <= count_q - CNT_ONE;
            default: count_q <= count_q;
         endcase
      end
   end

   // Entry storage.
   // NOTE: the payload array is deliberately not reset; a slot is only
   // meaningful while covered by count, so clearing it would buy nothing.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_req;
   end

   // A slot is live when its distance from the read pointer is below count.
   // NOTE: every output of this block gets a default first, so no path
   // through it leaves a value unassigned and no latch is inferred.
   always_comb begin
      entry_addr  = '0;
      entry_valid = '0;
      for (int i = 0; i < DEPTH; i++) begin
         entry_addr[i]  = mem[i].addr;
         entry_valid[i] = ({1'b0, PTR_W'(i) - rd_ptr} < count_q);
      end
   end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Register-file write-port arbiter.
// The writeback stage owns the port whenever it asks; multi-cycle-unit
// writes wait in a small FIFO and drain in idle slots. If the FIFO is
// held off for too long the arbiter asks the pipeline for one bubble.
module regfile_wr_arbiter
   import regfile_pkg::*;
#(
   parameter int DEPTH      = 4,
   parameter int STARVE_MAX = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wb_wr,
   input  logic [REG_ADDR_W-1:0] wb_addr,
   input  logic [DATA_W-1:0]     wb_data,
   input  logic                  mc_valid,
   output logic                  mc_ready,
   input  logic [REG_ADDR_W-1:0] mc_addr,
   input  logic [DATA_W-1:0]     mc_data,
   output logic                  rf_wr,
   output logic [REG_ADDR_W-1:0] rf_addr_wr,
   output logic [DATA_W-1:0]     rf_din,
   output logic [NUM_REGS-1:0]   pend_busy,
   output logic                  stall_req,
   output logic                  proto_err
);

   localparam int                   CNT_W        = $clog2(DEPTH) + 1;
   localparam logic [CNT_W-1:0]     FULL_COUNT   = CNT_W'(DEPTH);
   localparam int                   STARVE_W     = $clog2(STARVE_MAX + 1);
   localparam logic [STARVE_W-1:0]  STARVE_LIMIT = STARVE_W'(STARVE_MAX);
   localparam logic [STARVE_W-1:0]  STARVE_ONE   = STARVE_W'(1);

   mc_req_t                          push_req;
   mc_req_t                          head;
   logic [CNT_W-1:0]                 fifo_count;
   logic                             fifo_empty;
   logic [DEPTH-1:0][REG_ADDR_W-1:0] entry_addr;
   logic [DEPTH-1:0]                 entry_valid;
   logic                             push;
   logic                             pop;
   grant_e                           grant;
   logic                             out_is_mc;
   starve_state_e                    state_q;
   starve_state_e                    state_d;
   logic [STARVE_W-1:0]              starve_q;
   logic [STARVE_W-1:0]              starve_d;

   // Acceptance depends on occupancy only: a full FIFO refuses even when
   // it is being popped in the same cycle.
   assign mc_ready      = (fifo_count != FULL_COUNT);
   assign push          = mc_valid && mc_ready;
   assign push_req.addr = mc_addr;
   assign push_req.data = mc_data;
   assign pop           = (grant == GRANT_MC);

   mc_wr_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push        (push),
      .push_req    (push_req),
      .pop         (pop),
      .head        (head),
      .count       (fifo_count),
      .empty       (fifo_empty),
      .entry_addr  (entry_addr),
      .entry_valid (entry_valid)
   );

   // Fixed priority: WB, then the FIFO head, else the port stays idle.
   always_comb begin
      grant = GRANT_IDLE;
      if (wb_wr)            grant = GRANT_WB;
      else if (!fifo_empty) grant = GRANT_MC;
   end

   // Output stage driving the register file; writes to r0 are suppressed
   // here, though an MC entry aimed at r0 has still been popped.
   always_ff @(posedge clk) begin
      if (rst) begin
         rf_wr      <= 1'b0;
         rf_addr_wr <= '0;
         rf_din     <= '0;
         out_is_mc  <= 1'b0;
      end else begin
         unique case (grant)
            GRANT_WB: begin
               rf_wr      <= (wb_addr != REG_ZERO);
               rf_addr_wr <= wb_addr;
               rf_din     <= wb_data;
               out_is_mc  <= 1'b0;
            end
            GRANT_MC: begin
               rf_wr      <= (head.addr != REG_ZERO);
               rf_addr_wr <= head.addr;
               rf_din     <= head.data;
               out_is_mc  <= 1'b1;
            end
            default: begin
               rf_wr      <= 1'b0;
               out_is_mc  <= 1'b0;
            end
         endcase
      end
   end

   // Starvation guard state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_RUN;
         starve_q <= '0;
      end else begin
         state_q  <= state_d;
         starve_q <= starve_d;
      end
   end

   // Count consecutive denied cycles (saturating); raise the bubble request
   // in the same edge the count reaches the limit, drop it after a pop.
   always_comb begin
      state_d  = state_q;
      starve_d = starve_q;
      if (pop || fifo_empty)
         starve_d = '0;
      else if (wb_wr && (starve_q != STARVE_LIMIT))
         starve_d = starve_q + STARVE_ONE;
      unique case (state_q)
         ST_RUN:   if (starve_d == STARVE_LIMIT) state_d = ST_STALL;
         ST_STALL: if (pop)                      state_d = ST_RUN;
         default:                                state_d = ST_RUN;
      endcase
   end

   assign stall_req = (state_q == ST_STALL);

   // Sticky flag: the pipeline issued a WB write while asked to hold off.
   always_ff @(posedge clk) begin
      if (rst)                    proto_err <= 1'b0;
      else if (wb_wr && stall_req) proto_err <= 1'b1;
   end

   // Registers with an MC write still in flight (queued or in the output
   // stage); r0 is never reported since it cannot be written.
   always_comb begin
      pend_busy = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (entry_valid[i]) pend_busy |= reg_onehot(entry_addr[i]);
      end
      if (out_is_mc && rf_wr) pend_busy |= reg_onehot(rf_addr_wr);
      pend_busy[REG_ZERO] = 1'b0;
   end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Self-checking bench for regfile_wr_arbiter: directed scenarios followed
// by randomized traffic, all compared against a queue-based reference model.
module tb_regfile_wr_arbiter;

   localparam int DEPTH      = 4;
   localparam int STARVE_MAX = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        wb_wr;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        mc_valid;
   logic        mc_ready;
   logic [4:0]  mc_addr;
   logic [31:0] mc_data;
   logic        rf_wr;
   logic [4:0]  rf_addr_wr;
   logic [31:0] rf_din;
   logic [31:0] pend_busy;
   logic        stall_req;
   logic        proto_err;

   always #5 clk = ~clk;

   regfile_wr_arbiter #(
      .DEPTH      (DEPTH),
      .STARVE_MAX (STARVE_MAX)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .wb_wr      (wb_wr),
      .wb_addr    (wb_addr),
      .wb_data    (wb_data),
      .mc_valid   (mc_valid),
      .mc_ready   (mc_ready),
      .mc_addr    (mc_addr),
      .mc_data    (mc_data),
      .rf_wr      (rf_wr),
      .rf_addr_wr (rf_addr_wr),
      .rf_din     (rf_din),
      .pend_busy  (pend_busy),
      .stall_req  (stall_req),
      .proto_err  (proto_err)
   );

   // Reference model state: the MC queue plus what the port shows next.
   typedef struct {
      logic [4:0]  addr;
      logic [31:0] data;
   } wr_t;

   wr_t         q[$];
   logic        m_wr;
   logic [4:0]  m_addr;
   logic [31:0] m_din;
   logic        m_mc;
   int          m_starve;
   logic        m_stall;
   logic        m_perr;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   // One clock of the rules, applied to the inputs currently driven.
   task automatic model_step();
      bit  had;
      bit  push_ok;
      wr_t e;
      if (rst) begin
         q.delete();
         m_wr = 0; m_addr = 0; m_din = 0; m_mc = 0;
         m_starve = 0; m_stall = 0; m_perr = 0;
         return;
      end
      had     = (q.size() > 0);
      push_ok = mc_valid && (q.size() < DEPTH);
      if (wb_wr && m_stall) m_perr = 1;
      if (wb_wr) begin
         m_wr = (wb_addr != 0); m_addr = wb_addr; m_din = wb_data; m_mc = 0;
      end else if (had) begin
         e = q.pop_front();
         m_wr = (e.addr != 0); m_addr = e.addr; m_din = e.data; m_mc = 1;
      end else begin
         m_wr = 0; m_mc = 0;
      end
      if (!had) begin
         m_starve = 0;
      end else if (!wb_wr) begin
         m_starve = 0;
         m_stall  = 0;
      end else begin
         if (m_starve < STARVE_MAX) m_starve++;
         if (m_starve == STARVE_MAX) m_stall = 1;
      end
      if (push_ok) begin
         e.addr = mc_addr; e.data = mc_data;
         q.push_back(e);
      end
   endtask

   function automatic logic [31:0] model_pend();
      logic [31:0] p;
      p = '0;
      foreach (q[i]) p[q[i].addr] = 1'b1;
      if (m_mc && m_wr) p[m_addr] = 1'b1;
      p[0] = 1'b0;
      return p;
   endfunction

   task automatic compare_all(input string ctx);
      check({ctx, ".rf_wr"}, rf_wr, m_wr);
      if (m_wr) begin
         check({ctx, ".rf_addr_wr"}, rf_addr_wr, m_addr);
         check({ctx, ".rf_din"}, rf_din, m_din);
      end
      check({ctx, ".stall_req"}, stall_req, m_stall);
      check({ctx, ".proto_err"}, proto_err, m_perr);
      check({ctx, ".mc_ready"}, mc_ready, (q.size() != DEPTH));
      check({ctx, ".pend_busy"}, pend_busy, model_pend());
   endtask

   // Drive one cycle of inputs at the falling edge, step the model, then
   // compare at the next falling edge.
   task automatic cycle(input logic r, input logic w, input logic [4:0] wa, input logic [31:0] wd,
                        input logic v, input logic [4:0] ma, input logic [31:0] md, input string ctx);
      rst = r; wb_wr = w; wb_addr = wa; wb_data = wd;
      mc_valid = v; mc_addr = ma; mc_data = md;
      model_step();
      @(negedge clk);
      compare_all(ctx);
   endtask

   initial begin
      int phase_wb_pct;
      bit polite;
      rst = 1'b1; wb_wr = 1'b0; wb_addr = '0; wb_data = '0;
      mc_valid = 1'b0; mc_addr = '0; mc_data = '0;
      @(negedge clk);

      // Reset held two cycles with an MC request pending.
      cycle(1, 0, 0, 0, 1, 5'd3, 32'h1111_0000, "rst0");
      cycle(1, 0, 0, 0, 1, 5'd3, 32'h1111_0000, "rst1");
      check("rst.rf_addr_wr", rf_addr_wr, 0);
      check("rst.rf_din", rf_din, 0);
      check("rst.mc_ready", mc_ready, 1);
      cycle(0, 0, 0, 0, 0, 0, 0, "post_rst0");
      cycle(0, 0, 0, 0, 0, 0, 0, "post_rst1");
      check("post_rst.pend_busy", pend_busy, 0);

      // Basic WB write, then a WB write to r0.
      cycle(0, 1, 5'd5, 32'hDEAD_BEEF, 0, 0, 0, "wb5");
      check("wb5.rf_wr", rf_wr, 1);
      check("wb5.rf_addr_wr", rf_addr_wr, 5);
      check("wb5.rf_din", rf_din, 32'hDEAD_BEEF);
      cycle(0, 1, 5'd0, 32'h1234_5678, 0, 0, 0, "wb0");
      check("wb0.rf_wr", rf_wr, 0);

      // Fill the FIFO under WB pressure, then drain in order.
      for (int i = 1; i <= 4; i++)
         cycle(0, 1, 5'd10, i, 1, 5'(i), 32'h100 + i, "fill");
      check("fill.mc_ready", mc_ready, 0);
      check("fill.pend_busy", pend_busy, 32'h1E);
      for (int i = 1; i <= 4; i++) begin
         cycle(0, 0, 0, 0, 0, 0, 0, "drain");
         check("drain.rf_wr", rf_wr, 1);
         check("drain.rf_addr_wr", rf_addr_wr, i);
      end
      cycle(0, 0, 0, 0, 0, 0, 0, "drained");
      check("drained.pend_busy", pend_busy, 0);

      // Starvation: one entry held off for STARVE_MAX cycles.
      cycle(0, 1, 5'd7, 32'h7, 1, 5'd9, 32'h900D, "starve_push");
      for (int i = 1; i <= STARVE_MAX; i++) begin
         if (i == STARVE_MAX) check("starve.pre", stall_req, 0);
         cycle(0, 1, 5'd7, 32'h7, 0, 0, 0, "starve");
      end
      check("starve.stall_req", stall_req, 1);
      cycle(0, 0, 0, 0, 0, 0, 0, "starve_pop");
      check("starve_pop.stall_req", stall_req, 0);
      check("starve_pop.rf_addr_wr", rf_addr_wr, 9);

      // Protocol error: keep writing while the bubble is requested.
      cycle(0, 1, 5'd7, 32'h7, 1, 5'd11, 32'hB, "perr_push");
      for (int i = 0; i < STARVE_MAX; i++)
         cycle(0, 1, 5'd7, 32'h7, 0, 0, 0, "perr_starve");
      cycle(0, 1, 5'd6, 32'h6, 0, 0, 0, "perr_hit");
      check("perr.proto_err", proto_err, 1);
      for (int i = 0; i < 3; i++)
         cycle(0, 0, 0, 0, 0, 0, 0, "perr_hold");
      check("perr_hold.proto_err", proto_err, 1);
      cycle(1, 0, 0, 0, 0, 0, 0, "perr_rst");
      check("perr_rst.proto_err", proto_err, 0);

      // Simultaneous push and pop at count 2, then reset with 3 queued.
      cycle(0, 1, 5'd1, 32'h1, 1, 5'd12, 32'hC, "pp_a");
      cycle(0, 1, 5'd1, 32'h1, 1, 5'd13, 32'hD, "pp_b");
      cycle(0, 0, 0, 0, 1, 5'd14, 32'hE, "pp_same");
      cycle(0, 1, 5'd1, 32'h1, 1, 5'd15, 32'hF, "pp_c");
      check("pp.mc_ready", mc_ready, 1);
      check("pp.pend_busy", pend_busy, 32'h0000_E000);
      cycle(1, 0, 0, 0, 0, 0, 0, "pp_rst");
      check("pp_rst.pend_busy", pend_busy, 0);
      check("pp_rst.mc_ready", mc_ready, 1);
      cycle(0, 0, 0, 0, 0, 0, 0, "pp_idle");

      // Randomized traffic in phases of varying WB pressure.
      phase_wb_pct = 50;
      polite = 1'b1;
      for (int n = 0; n < 4000; n++) begin
         logic r, w, v;
         if (n % 64 == 0) begin
            case ($urandom_range(0, 3))
               0: phase_wb_pct = 10;
               1: phase_wb_pct = 50;
               2: phase_wb_pct = 85;
               default: phase_wb_pct = 100;
            endcase
            polite = ($urandom_range(0, 3) != 0);
         end
         r = ($urandom_range(0, 299) == 0);
         w = ($urandom_range(0, 99) < phase_wb_pct);
         if (polite && m_stall) w = 1'b0;
         v = ($urandom_range(0, 1) == 1);
         cycle(r, w, 5'($urandom_range(0, 31)), $urandom, v,
               5'($urandom_range(0, 31)), $urandom, "rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/regfile_wr_arbiter.md
Name: regfile_wr_arbiter

Overview:
- Shares the single register-file write port between the pipeline writeback stage (WB) and the multi-cycle unit (MC: mul/div, late loads).
- WB has fixed priority and no backpressure. MC writes use a valid/ready handshake and queue in a small FIFO.
- Outputs drive the register file's wr/Addr_Wr/Din inputs. A pending-write vector is exported to the hazard unit.
- A starvation counter requests a one-slot pipeline bubble so that MC writes always drain.

Parameters:
- DEPTH, 4, MC FIFO entries; power of two, >= 2.
- STARVE_MAX, 8, consecutive denied MC cycles before stall_req asserts; >= 1.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- wb_wr  in  1  WB write request; always accepted
- wb_addr  in  5  WB destination register
- wb_data  in  32  WB write data
- mc_valid  in  1  MC write request valid
- mc_ready  out  1  MC FIFO can accept; = (count != DEPTH)
- mc_addr  in  5  MC destination register
- mc_data  in  32  MC write data
- rf_wr  out  1  register-file write enable (registered)
- rf_addr_wr  out  5  register-file write address (registered)
- rf_din  out  32  register-file write data (registered)
- pend_busy  out  32  bit i = MC write to register i is queued or in the output stage
- stall_req  out  1  request to the pipeline: no wb_wr next cycle (registered)
- proto_err  out  1  sticky; wb_wr seen while stall_req = 1

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high on rst.
- Reset values: rf_wr=0, rf_addr_wr=0, rf_din=0, stall_req=0, proto_err=0, FIFO empty, starve count=0.
  - pend_busy=0 and mc_ready=1 follow from the empty FIFO.
- Reset mid-operation:
  - All queued MC writes are discarded.
  - An rf_wr asserted in the cycle rst is sampled is deasserted at that edge.
- Grant, evaluated each cycle:
  - wb_wr=1 → WB wins.
  - Otherwise, FIFO non-empty → pop the head.
  - Otherwise → idle.
- Latency:
  - WB request in cycle N → rf_* valid in N+1; the register file writes at the end of N+1.
  - MC push in cycle N → earliest pop in N+1 → rf_* in N+2.
- r0 filter: a granted write with addr=0 produces rf_wr=0 in the output cycle.
  - WB: no side effect.
  - MC: the entry is still popped, and pend_busy[0] is always 0.
- FIFO:
  - Push on mc_valid & mc_ready.
  - mc_ready depends on count only. When full, no push is accepted even in a pop cycle.
  - Pointers wrap modulo DEPTH; count width is log2(DEPTH)+1.
  - Push and pop in the same cycle leave count unchanged.
- pend_busy:
  - OR over valid FIFO entries of the one-hot(addr), plus one-hot(rf_addr_wr) when the output stage holds an MC write with rf_wr=1.
  - Combinational from state.
- Ordering:
  - No reordering and no address-conflict checks.
  - A later MC write overrides an earlier WB write to the same register. The hazard unit must use pend_busy to prevent WAW/RAW conflicts.
- Starvation:
  - Count increments each cycle with FIFO non-empty and wb_wr=1 (MC denied).
  - Count clears on any cycle with a pop or an empty FIFO.
  - When count reaches STARVE_MAX, stall_req=1 from the next edge.
  - stall_req holds until the edge after the first pop, then clears, with count=0.
- Protocol error: wb_wr=1 while stall_req=1 sets proto_err, which holds until rst. WB still wins that cycle.

Decomposition:
- Shared package regfile_pkg: DATA_W=32, REG_ADDR_W=5, NUM_REGS=32, REG_ZERO=0, and an mc_req struct {addr, data}.
- One sub-module: mc_wr_fifo, a synchronous FIFO parameterised by DEPTH.
  - Exposes count and per-entry addr/valid so the arbiter can build pend_busy.

Test Plan:
- Assert rst for 2 cycles with mc_valid=1 → all outputs at reset values, mc_ready=1, nothing queued after release.
- WB wb_addr=5, wb_data=0xDEADBEEF in cycle N → rf_wr=1, rf_addr_wr=5, rf_din=0xDEADBEEF in N+1. WB to r0 → rf_wr stays 0.
- Hold wb_wr=1 and push 4 MC writes (r1..r4) → mc_ready=0 after the 4th, pend_busy=0x1E.
  - Drop wb_wr → r1..r4 written in 4 consecutive cycles, in order.
  - pend_busy clears bit by bit, reaching 0 after the last output cycle.
- STARVE_MAX=8: one MC entry queued and wb_wr=1 for 8 cycles → stall_req=1 in cycle 9.
  - Bench drops wb_wr → pop occurs, stall_req=0 the next cycle.
- wb_wr=1 while stall_req=1 → proto_err=1, and it stays set until rst.
- Push and pop in the same cycle at count=2 → count stays 2. With 3 queued entries, assert rst → FIFO empty, pend_busy=0 at the next edge.
